// File: rtl/block_memory_responder.sv
// block_memory_responder
// Main-memory side of the cache block-fill interface. A level request on
// req is answered with the aligned 4-word block holding address, exactly
// LATENCY clock edges after the request is accepted. A single-word write
// port preloads or patches memory while no read is pending.
// Optional feature: define MEM_READ_STATS_EN to add the saturating readCount output.

module block_memory_responder #(
   parameter int LATENCY    = 4,
   parameter int ADDR_WIDTH = 15,
   parameter int WORD_SIZE  = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   req,
   input  logic [ADDR_WIDTH-1:0]  address,
   input  logic                   wr,
   input  logic [WORD_SIZE-1:0]   wrData,
   output logic [4*WORD_SIZE-1:0] dataOut,
   output logic                   dataValid,
   output logic                   busy,
   output logic                   wrAck
`ifdef MEM_READ_STATS_EN
   ,
   output logic [15:0]            readCount
`endif
);

   localparam int DEPTH      = 1 << ADDR_WIDTH;
   localparam int BASE_WIDTH = ADDR_WIDTH - 2;
   localparam logic [7:0] COUNT_LOAD = 8'(LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP,
      DONE
   } respState_t;

   respState_t            state;
   respState_t            nextState;
   logic                  acceptRead;
   logic                  acceptWrite;
   logic [7:0]            latencyCount;
   logic [BASE_WIDTH-1:0] blockBase;
   logic [4*WORD_SIZE-1:0] blockWords;

   // Words are stored XORed with their own address. A zeroed array therefore
   // reads back as word i == i, which gives the required power-up image
   // without an init file and without a reset sweep over the whole array.
   logic [WORD_SIZE-1:0]  memStore [DEPTH] = '{default: '0};

   // FSM state register.
   // NOTE: every clocked block uses non-blocking assignments so all registers
   // update from pre-edge values and the order of blocks never matters.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= nextState;
   end

   // Next-state decode plus the read/write acceptance strobes.
   // NOTE: every output of this block is given a default first, so no path
   // leaves a signal unassigned and no latch is inferred.
   always_comb begin
      nextState   = state;
      acceptRead  = 1'b0;
      acceptWrite = 1'b0;
      case (state)
         IDLE: begin
            if (req) begin
               // A read always beats a simultaneous write; the write is dropped.
               acceptRead = 1'b1;
               nextState  = (LATENCY == 1) ? RESP : WAIT;
            end else if (wr) begin
               acceptWrite = 1'b1;
            end
         end
         WAIT: if (latencyCount <= 8'd1) nextState = RESP;
         RESP: nextState = DONE;
         // Hold here until the cache lets go of this block, so a memRead left
         // high on the same block is not served twice.
         DONE: if (!req || (address[ADDR_WIDTH-1:2] != blockBase)) nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // Gather the four words of the latched block; offset k lands in slice k.
   always_comb begin
      blockWords = '0;
      for (int k = 0; k < 4; k++) begin
         blockWords[k*WORD_SIZE +: WORD_SIZE] =
            memStore[{blockBase, 2'(k)}] ^ WORD_SIZE'({blockBase, 2'(k)});
      end
   end

   // Request latch, latency counter and the registered handshake outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         dataOut      <= '0;
         dataValid    <= 1'b0;
         busy         <= 1'b0;
         wrAck        <= 1'b0;
         latencyCount <= '0;
         blockBase    <= '0;
      end else begin
         dataValid <= (state == RESP);
         wrAck     <= acceptWrite;
         busy      <= (nextState != IDLE);
         if (acceptRead) begin
            blockBase    <= address[ADDR_WIDTH-1:2];
            latencyCount <= COUNT_LOAD;
         end else if ((state == WAIT) && (latencyCount != 8'd0)) begin
            latencyCount <= latencyCount - 8'd1;
         end
         // dataOut is only replaced by a new response, never cleared in IDLE.
         if (state == RESP) dataOut <= blockWords;
      end
   end

   // Single-word write port into the storage array.
   // NOTE: the array has no reset on purpose: its contents must survive rst,
   // and a reset would also keep it from mapping onto block RAM.
   always_ff @(posedge clk) begin
      if (acceptWrite) memStore[address] <= wrData ^ WORD_SIZE'(address);
   end

`ifdef MEM_READ_STATS_EN
   // Count responses started since reset, sticking at all-ones.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         readCount <= '0;
      end else if ((nextState == RESP) && (readCount != 16'hFFFF)) begin
         readCount <= readCount + 16'd1;
      end
   end
`endif

endmodule
